// File: rtl/wb_slave_model.sv
// Wishbone B4 pipelined slave model: word memory behind an in-order response queue
// with fixed ack latency, bounded outstanding depth, forced stalls and read-data injection.
module wb_slave_model #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_DEPTH       = 256,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ACK_LATENCY     = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic                    wb_we_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  output logic                    wb_ack_o,
  output logic                    wb_stall_o,
  input  logic                    stall_req_i,
  input  logic                    inject_en_i,
  input  logic [DATA_WIDTH-1:0]   injected_data_i
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(SEL_WIDTH);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam int PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int REM_W     = $clog2(ACK_LATENCY + 1);

  localparam logic [CNT_W-1:0] FULL     = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(ACK_LATENCY - 1);

  logic [DATA_WIDTH-1:0]      mem    [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]      data_q [MAX_OUTSTANDING];
  logic [REM_W-1:0]           rem_q  [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] valid_q;
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W-1:0]           wr_ptr;
  logic [CNT_W-1:0]           count;

  logic [IDX_W-1:0]           index;
  logic [DATA_WIDTH-1:0]      rd_data;
  logic                       accept;
  logic                       ack;
  logic                       unused_adr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [SEL_WIDTH-1:0]  lanes
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_word;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      if (lanes[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

  // Word index drops the byte offset and every bit above the memory size.
  assign index      = wb_adr_i[OFF_W +: IDX_W];
  assign unused_adr = ^wb_adr_i;

  assign wb_stall_o = stall_req_i | (count == FULL);
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign rd_data    = inject_en_i ? injected_data_i : mem[index];

  // Response side: only registered queue state plus cyc feeds the ack.
  assign ack      = valid_q[rd_ptr] & (rem_q[rd_ptr] == '0) & wb_cyc_i;
  assign wb_ack_o = ack;
  assign wb_dat_o = ack ? data_q[rd_ptr] : '0;

  // Stage p0: commit accepted writes to storage.
  always_ff @(posedge clk_i) begin
    if (accept && wb_we_i) mem[index] <= merge_lanes(mem[index], wb_dat_i, wb_sel_i);
  end

  // Stage p1: queue payload and latency countdown (data path, never reset).
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (rem_q[i] != '0) rem_q[i] <= rem_q[i] - 1'b1;
    end
    if (accept) begin
      data_q[wr_ptr] <= wb_we_i ? '0 : rd_data;
      rem_q[wr_ptr]  <= REM_INIT;
    end
  end

  // Stage p2: queue occupancy control; dropping cyc discards everything pending.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else if (!wb_cyc_i) begin
      valid_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      if (ack) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= next_ptr(rd_ptr);
      end
      if (accept) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      case ({accept, ack})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_model.sv
// Directed bench for wb_slave_model: two instances (latency 1 / depth 4 and latency 3 / depth 2)
// share one bus; a scoreboard of expected {data, ack cycle} is checked on every falling edge.
module tb_wb_slave_model;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat_w, inj_data;
  logic        we, stb_a, stb_b, cyc, stall_req, inject;
  logic [3:0]  sel;
  logic [31:0] dat_a, dat_b;
  logic        ack_a, ack_b, stall_a, stall_b;

  always #5 clk = ~clk;

  wb_slave_model #(.ACK_LATENCY(1), .MAX_OUTSTANDING(4)) u_a (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_a),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb_a), .wb_cyc_i(cyc), .wb_ack_o(ack_a),
    .wb_stall_o(stall_a), .stall_req_i(stall_req), .inject_en_i(inject),
    .injected_data_i(inj_data));

  wb_slave_model #(.ACK_LATENCY(3), .MAX_OUTSTANDING(2)) u_b (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_b),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb_b), .wb_cyc_i(cyc), .wb_ack_o(ack_b),
    .wb_stall_o(stall_b), .stall_req_i(stall_req), .inject_en_i(inject),
    .injected_data_i(inj_data));

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   failures = 0;
  int   cnt = 0;
  bit   s0, s1, s2, s3;

  always @(posedge clk) cnt <= cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon(input bit b, input string nm, input logic ack, input logic [31:0] d);
    exp_t h;
    int   sz;
    bit   exp_ack;
    sz = b ? q_b.size() : q_a.size();
    if (sz > 0) h = b ? q_b[0] : q_a[0];
    if (rst || !cyc) begin
      check($sformatf("%s_ack_idle", nm), ack, 0);
      if (b) q_b.delete(); else q_a.delete();
      return;
    end
    exp_ack = (sz > 0) && (h.cyc == cnt);
    check($sformatf("%s_ack@%0d", nm, cnt), ack, exp_ack);
    if (exp_ack) check($sformatf("%s_data@%0d", nm, cnt), d, h.data);
    else         check($sformatf("%s_dat_zero@%0d", nm, cnt), d, 0);
    if (sz > 0 && h.cyc <= cnt) begin
      if (b) void'(q_b.pop_front()); else void'(q_a.pop_front());
    end
  endtask

  always @(negedge clk) begin
    mon(1'b0, "a", ack_a, dat_a);
    mon(1'b1, "b", ack_b, dat_b);
  end

  // Drive one request and hold it until accepted; the next call makes it back-to-back.
  task automatic req(input bit b, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] e, output bit stalled);
    int n = 0;
    @(posedge clk); #1;
    we = w; adr = a; dat_w = d; sel = s;
    stb_a = ~b; stb_b = b;
    @(negedge clk);
    stalled = b ? stall_b : stall_a;
    while ((b ? stall_b : stall_a) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", n, n < 50 ? n : 0);
    if (b) q_b.push_back('{data: e, cyc: cnt + 3});
    else   q_a.push_back('{data: e, cyc: cnt + 1});
  endtask

  task automatic end_req();
    @(posedge clk); #1;
    stb_a = 1'b0; stb_b = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q_a.size() + q_b.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", q_a.size() + q_b.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb_a = 1'b0; stb_b = 1'b0; we = 1'b0; adr = '0;
    dat_w = '0; sel = '0; stall_req = 1'b0; inject = 1'b0; inj_data = '0;
    repeat (2) @(negedge clk);
    check("rst_ack_a", ack_a, 0);
    check("rst_dat_a", dat_a, 0);
    check("rst_stall_a", stall_a, 0);
    check("rst_ack_b", ack_b, 0);
    check("rst_stall_b", stall_b, 0);
    stall_req = 1'b1; #1;
    check("rst_stall_follow", stall_a, 1);
    stall_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b1;

    // Latency 1: write then read back.
    req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, s0);
    req(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, s0);
    end_req(); wait_idle();

    // Byte lanes 0 and 2 only; read ignores sel.
    req(0, 1, 32'h10, 32'h11223344, 4'hF, 32'h0, s0);
    req(0, 1, 32'h10, 32'hAABBCCDD, 4'b0101, 32'h0, s0);
    req(0, 0, 32'h10, 32'h0, 4'h0, 32'h11BB33DD, s0);
    end_req(); wait_idle();

    // Address wrap: 0x400 is word 256, which aliases word 0.
    req(0, 1, 32'h000, 32'h5A5A5A5A, 4'hF, 32'h0, s0);
    req(0, 0, 32'h400, 32'h0, 4'hF, 32'h5A5A5A5A, s0);
    end_req(); wait_idle();

    // Injection.
    inject = 1'b1; inj_data = 32'hCAFEF00D;
    req(0, 0, 32'h10, 32'h0, 4'hF, 32'hCAFEF00D, s0);
    end_req(); wait_idle();
    inject = 1'b0;

    // Forced stall blocks a write for three cycles.
    req(0, 1, 32'h20, 32'h12345678, 4'hF, 32'h0, s0);
    end_req(); wait_idle();
    @(posedge clk); #1;
    stall_req = 1'b1; we = 1'b1; adr = 32'h20; dat_w = 32'hFFFFFFFF; sel = 4'hF; stb_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("forced_stall", stall_a, 1);
    end
    @(posedge clk); #1;
    stb_a = 1'b0; stall_req = 1'b0;
    req(0, 0, 32'h20, 32'h0, 4'hF, 32'h12345678, s0);
    end_req(); wait_idle();

    // Latency 3, depth 2: fill, then four back-to-back reads.
    for (int i = 0; i < 4; i++) req(1, 1, 32'(4 * i), 32'hB0000000 + 32'(i), 4'hF, 32'h0, s0);
    end_req(); wait_idle();
    req(1, 0, 32'h0, 32'h0, 4'hF, 32'hB0000000, s0);
    req(1, 0, 32'h4, 32'h0, 4'hF, 32'hB0000001, s1);
    req(1, 0, 32'h8, 32'h0, 4'hF, 32'hB0000002, s2);
    req(1, 0, 32'hC, 32'h0, 4'hF, 32'hB0000003, s3);
    end_req(); wait_idle();
    check("b_stall_1st", s0, 0);
    check("b_stall_2nd", s1, 0);
    check("b_stall_full", s2, 1);
    check("b_stall_4th", s3, 0);

    // Abort: drop cyc with two reads in flight.
    req(1, 0, 32'h0, 32'h0, 4'hF, 32'hB0000000, s0);
    req(1, 0, 32'h4, 32'h0, 4'hF, 32'hB0000001, s0);
    @(posedge clk); #1;
    stb_b = 1'b0; cyc = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    cyc = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_stall_clear", stall_b, 0);
    req(1, 0, 32'h8, 32'h0, 4'hF, 32'hB0000002, s0);
    end_req(); wait_idle();

    // Reset while the first of two reads is being acked.
    req(1, 0, 32'h0, 32'h0, 4'hF, 32'hB0000000, s0);
    req(1, 0, 32'hC, 32'h0, 4'hF, 32'hB0000003, s0);
    end_req();
    check("pre_rst_stall", stall_b, 1);
    @(posedge clk); #2;
    check("pre_rst_ack", ack_b, 1);
    check("pre_rst_data", dat_b, 32'hB0000000);
    rst = 1'b1; #1;
    check("mid_rst_ack", ack_b, 0);
    check("mid_rst_dat", dat_b, 0);
    check("mid_rst_stall", stall_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    req(1, 0, 32'h4, 32'h0, 4'hF, 32'hB0000001, s0);
    end_req(); wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
